// File: rtl/rv_alu_pkg.sv
// Shared ALU operation encodings and result-entry type used by the
// ALU-operation decoder and the execute stage.
package rv_alu_pkg;

    localparam int ALU_OP_W = 3;
    localparam int ALU_XLEN = 32;
    localparam int ALU_RD_W = 5;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_EQ  = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_LT  = 3'b101;

    typedef struct packed {
        logic [ALU_XLEN-1:0] result;
        logic                cond;
        logic [ALU_RD_W-1:0] rd;
        logic                we;
        logic                illegal;
    } alu_entry_t;

    // Compare ops are the only ones whose result bit 0 drives the branch condition.
    function automatic logic is_cond_op(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_EQ) || (op == ALU_LT);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: op/a/b to result, branch condition and
// reserved-code detection.
module alu_core
    import rv_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [ALU_OP_W-1:0] op_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic [XLEN-1:0]     result_o,
    output logic                cond_o,
    output logic                illegal_o
);

    // Operation select; reserved codes yield a zero result and flag illegal.
    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        case (op_i)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_EQ:  result_o = {{(XLEN-1){1'b0}}, (a_i == b_i)};
            ALU_LT:  result_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: illegal_o = 1'b1;
        endcase
        cond_o = is_cond_op(op_i) & result_o[0];
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: one-cycle latency, valid/ready handshake
// with an output register plus a one-entry skid register.
module alu_exec_stage
    import rv_alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] in_alu_op,
    input  logic [XLEN-1:0]     in_a,
    input  logic [XLEN-1:0]     in_b,
    input  logic [RD_W-1:0]     in_rd,
    input  logic                in_we,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_result,
    output logic                out_zero,
    output logic                out_cond,
    output logic [RD_W-1:0]     out_rd,
    output logic                out_we,
    output logic                out_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic            cond;
        logic [RD_W-1:0] rd;
        logic            we;
        logic            illegal;
    } entry_t;

    entry_t     or_q, or_d;
    entry_t     sk_q, sk_d;
    logic       or_valid_q, or_valid_d;
    logic       sk_valid_q, sk_valid_d;
    entry_t     comp_s;
    logic [XLEN-1:0] core_result_s;
    logic       core_cond_s;
    logic       core_illegal_s;
    logic       fire_s;
    logic       or_load_s;

    alu_core #(.XLEN(XLEN)) u_alu_core (
        .op_i      (in_alu_op),
        .a_i       (in_a),
        .b_i       (in_b),
        .result_o  (core_result_s),
        .cond_o    (core_cond_s),
        .illegal_o (core_illegal_s)
    );

    // Build the entry captured on a fire; illegal ops never write back.
    always_comb begin
        comp_s         = '0;
        comp_s.result  = core_result_s;
        comp_s.cond    = core_cond_s;
        comp_s.rd      = in_rd;
        comp_s.we      = in_we & ~core_illegal_s;
        comp_s.illegal = core_illegal_s;
    end

    assign in_ready  = ~sk_valid_q;
    assign fire_s    = in_valid & in_ready & ~flush;
    assign or_load_s = ~or_valid_q | out_ready;

    // Next-state for output and skid registers; flush overrides everything.
    always_comb begin
        or_d       = or_q;
        sk_d       = sk_q;
        or_valid_d = or_valid_q;
        sk_valid_d = sk_valid_q;
        if (flush) begin
            or_valid_d = 1'b0;
            sk_valid_d = 1'b0;
        end else if (or_load_s) begin
            // SK valid implies in_ready=0, so no fire can collide with the move.
            if (sk_valid_q) begin
                or_d       = sk_q;
                or_valid_d = 1'b1;
                sk_valid_d = 1'b0;
            end else if (fire_s) begin
                or_d       = comp_s;
                or_valid_d = 1'b1;
            end else begin
                or_valid_d = 1'b0;
            end
        end else begin
            if (fire_s) begin
                sk_d       = comp_s;
                sk_valid_d = 1'b1;
            end else begin
                sk_valid_d = sk_valid_q;
            end
        end
    end

    // Stage state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_q       <= '0;
            sk_q       <= '0;
            or_valid_q <= 1'b0;
            sk_valid_q <= 1'b0;
        end else begin
            or_q       <= or_d;
            sk_q       <= sk_d;
            or_valid_q <= or_valid_d;
            sk_valid_q <= sk_valid_d;
        end
    end

    assign out_valid   = or_valid_q;
    assign out_result  = or_q.result;
    assign out_zero    = (or_q.result == '0);
    assign out_cond    = or_q.cond;
    assign out_rd      = or_q.rd;
    assign out_we      = or_q.we;
    assign out_illegal = or_q.illegal;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios followed by
// random traffic, compared against a two-deep FIFO reference model.
module tb_alu_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_alu_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [4:0]  in_rd;
    logic        in_we;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_cond;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] result;
        logic        cond;
        logic [4:0]  rd;
        logic        we;
        logic        illegal;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .in_we(in_we),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_cond(out_cond), .out_rd(out_rd),
        .out_we(out_we), .out_illegal(out_illegal)
    );

    function automatic exp_t ref_calc(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic [4:0] rd,
                                      input logic we);
        exp_t e;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.rd = rd; e.we = we; e.illegal = 1'b0; e.cond = 1'b0; e.result = 32'd0;
        if (op == 3'd0)      e.result = 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
        else if (op == 3'd1) e.result = 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
        else if (op == 3'd2) e.result = a & b;
        else if (op == 3'd3) e.result = a | b;
        else if (op == 3'd4) begin e.result = (a == b) ? 32'd1 : 32'd0; e.cond = (a == b); end
        else if (op == 3'd5) begin e.result = (sa < sb) ? 32'd1 : 32'd0; e.cond = (sa < sb); end
        else begin e.illegal = 1'b1; e.we = 1'b0; end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk("out_result", out_result, q[0].result);
            chk("out_zero", 32'(out_zero), 32'(q[0].result == 32'd0));
            chk("out_cond", 32'(out_cond), 32'(q[0].cond));
            chk("out_rd", 32'(out_rd), 32'(q[0].rd));
            chk("out_we", 32'(out_we), 32'(q[0].we));
            chk("out_illegal", 32'(out_illegal), 32'(q[0].illegal));
        end
    endtask

    task automatic check_reset_values();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd1);
        chk("rst_out_cond", 32'(out_cond), 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_out_we", 32'(out_we), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    endtask

    // One cycle: drive at negedge, advance the model, check #1 after posedge.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic we,
                        input logic ordy, input logic fl);
        bit can_take;
        @(negedge clk);
        in_valid = v; in_alu_op = op; in_a = a; in_b = b; in_rd = rd; in_we = we;
        out_ready = ordy; flush = fl;
        can_take = (q.size() < 2);
        if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (v && can_take) q.push_back(ref_calc(op, a, b, rd, we));
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [31:0] held;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_alu_op = 3'd0;
        in_a = 32'd0; in_b = 32'd0; in_rd = 5'd0; in_we = 1'b0; out_ready = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD wrap into sign bit
        step(1'b1, 3'd0, 32'h7FFF_FFFF, 32'd1, 5'd3, 1'b1, 1'b1, 1'b0);
        chk("add_result", out_result, 32'h8000_0000);
        // Back-to-back SUB then EQ
        step(1'b1, 3'd1, 32'd5, 32'd5, 5'd4, 1'b1, 1'b1, 1'b0);
        chk("sub_zero", 32'(out_zero), 32'd1);
        step(1'b1, 3'd4, 32'h10, 32'h10, 5'd5, 1'b1, 1'b1, 1'b0);
        chk("eq_cond", 32'(out_cond), 32'd1);
        // Signed compares
        step(1'b1, 3'd5, 32'hFFFF_FFFF, 32'd1, 5'd6, 1'b1, 1'b1, 1'b0);
        chk("lt_neg_cond", 32'(out_cond), 32'd1);
        step(1'b1, 3'd5, 32'd1, 32'hFFFF_FFFF, 5'd7, 1'b1, 1'b1, 1'b0);
        chk("lt_pos_result", out_result, 32'd0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);

        // Backpressure: op1 in OR, op2 in SK, op3 stalls
        step(1'b1, 3'd0, 32'd100, 32'd1, 5'd1, 1'b1, 1'b0, 1'b0);
        held = out_result;
        step(1'b1, 3'd2, 32'hF0F0, 32'hFF00, 5'd2, 1'b1, 1'b0, 1'b0);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        step(1'b1, 3'd3, 32'h0F, 32'hF0, 5'd3, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd3, 32'h0F, 32'hF0, 5'd3, 1'b1, 1'b0, 1'b0);
        chk("stall_stable", out_result, held);
        step(1'b1, 3'd3, 32'h0F, 32'hF0, 5'd3, 1'b1, 1'b1, 1'b0);
        step(1'b1, 3'd3, 32'h0F, 32'hF0, 5'd3, 1'b1, 1'b1, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);

        // Reserved op with write enable requested
        step(1'b1, 3'd7, 32'd9, 32'd9, 5'd9, 1'b1, 1'b1, 1'b0);
        chk("illegal_flag", 32'(out_illegal), 32'd1);
        chk("illegal_we", 32'(out_we), 32'd0);
        step(1'b1, 3'd6, 32'd1, 32'd2, 5'd8, 1'b1, 1'b1, 1'b0);

        // Flush with both registers full and an input presented
        step(1'b1, 3'd0, 32'd1, 32'd1, 5'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd0, 32'd2, 32'd2, 5'd2, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd0, 32'd3, 32'd3, 5'd3, 1'b1, 1'b0, 1'b1);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), $urandom(),
                 ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom(), 5'($urandom()),
                 1'($urandom()), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
        end

        // Asynchronous reset mid-stream
        step(1'b1, 3'd0, 32'd7, 32'd8, 5'd9, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd1, 32'd7, 32'd8, 5'd9, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 3'd2, 32'hFF, 32'h0F, 5'd1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
